// File: rtl/sa_pkg.sv
// Shared constants for the systolic-array tile scheduler: element/column geometry,
// default operand sizes and the scheduler state encoding.
package sa_pkg;

  localparam int ELEM_W  = 8;
  localparam int SA_COLS = 64;

  localparam int S_DEF   = 2;
  localparam int X_R_DEF = 2;

  localparam int X_W_DEF   = S_DEF * X_R_DEF * ELEM_W;
  localparam int W_W_DEF   = S_DEF * SA_COLS * ELEM_W;
  localparam int RES_W_DEF = X_R_DEF * SA_COLS * ELEM_W;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_LD_W = 4'd1,
    ST_LD_X = 4'd2,
    ST_CAP  = 4'd3,
    ST_FIRE = 4'd4,
    ST_WAIT = 4'd5,
    ST_PUSH = 4'd6,
    ST_DONE = 4'd7,
    ST_ERR  = 4'd8
  } sa_state_t;

endpackage

// File: rtl/sa_watchdog.sv
// Cycle counter for the SA wait phase; expired rises once TIMEOUT cycles have
// elapsed since the last load.
module sa_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;

  // Expiry is decoded one count early so the owner leaves its wait state on
  // the TIMEOUT-th waiting cycle.
  assign expired = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sa_tile_scheduler.sv
// Sequencer between activation/weight buffers and the systolic-array wrapper:
// one weight load per job, then per X row-block read, fire, wait and push.
// Optional SA watchdog with sticky error state enabled by SA_SCHED_TIMEOUT_EN.
module sa_tile_scheduler
  import sa_pkg::*;
#(
  parameter int S       = S_DEF,
  parameter int X_R     = X_R_DEF,
  parameter int BLK_W   = 8,
  parameter int TIMEOUT = 1024
) (
  input  logic                          I_CLK,
  input  logic                          I_RST,
  input  logic                          I_START,
  input  logic [BLK_W-1:0]              I_NUM_BLK,
  output logic                          O_BUSY,
  output logic                          O_DONE,
  output logic                          O_ERR,
  output logic                          O_W_RD_EN,
  input  logic [S*SA_COLS*ELEM_W-1:0]   I_W_RD_DATA,
  output logic                          O_X_RD_EN,
  output logic [BLK_W-1:0]              O_X_RD_ADDR,
  input  logic [S*X_R*ELEM_W-1:0]       I_X_RD_DATA,
  output logic                          O_SA_START,
  output logic [S*X_R*ELEM_W-1:0]       O_SA_X,
  output logic [S*SA_COLS*ELEM_W-1:0]   O_SA_W,
  input  logic                          I_SA_OUT_VLD,
  input  logic [X_R*SA_COLS*ELEM_W-1:0] I_SA_OUT,
  output logic                          O_RES_VLD,
  output logic [X_R*SA_COLS*ELEM_W-1:0] O_RES,
  output logic [BLK_W-1:0]              O_RES_IDX,
  input  logic                          I_RES_RDY,
  output sa_state_t                     O_DBG_STATE
);

  sa_state_t                   state;
  logic [BLK_W-1:0]            num_blk;
  logic [BLK_W-1:0]            blk;
  logic                        w_loaded;
  logic [S*X_R*ELEM_W-1:0]     x_q;
  logic [S*SA_COLS*ELEM_W-1:0] w_q;
  logic                        accept;
  logic                        last_blk;

  assign O_DBG_STATE = state;
  assign O_SA_X      = x_q;
  assign O_SA_W      = w_q;
  assign last_blk    = (blk == num_blk - 1'b1);

`ifdef SA_SCHED_TIMEOUT_EN
  logic err_q;
  logic wd_expired;

  sa_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (I_CLK),
    .rst    (I_RST),
    .load   (state == ST_FIRE),
    .en     (state == ST_WAIT),
    .expired(wd_expired)
  );

  assign accept = I_START && ((state == ST_IDLE) || (state == ST_ERR));
  assign O_ERR  = err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT != 0);
  assign accept         = I_START && (state == ST_IDLE);
  assign O_ERR          = 1'b0;
`endif

  // Result handshake: O_RES_VLD rises with O_RES/O_RES_IDX already valid and all
  // three hold unchanged until a rising edge that also sees I_RES_RDY=1; that
  // edge is the transfer. I_RES_RDY is ignored whenever O_RES_VLD is low.
  always_ff @(posedge I_CLK or posedge I_RST) begin
    if (I_RST) begin
      state       <= ST_IDLE;
      num_blk     <= '0;
      blk         <= '0;
      w_loaded    <= 1'b0;
      x_q         <= '0;
      w_q         <= '0;
      O_BUSY      <= 1'b0;
      O_DONE      <= 1'b0;
      O_W_RD_EN   <= 1'b0;
      O_X_RD_EN   <= 1'b0;
      O_X_RD_ADDR <= '0;
      O_SA_START  <= 1'b0;
      O_RES_VLD   <= 1'b0;
      O_RES       <= '0;
      O_RES_IDX   <= '0;
`ifdef SA_SCHED_TIMEOUT_EN
      err_q       <= 1'b0;
`endif
    end else begin
      O_DONE     <= 1'b0;
      O_W_RD_EN  <= 1'b0;
      O_X_RD_EN  <= 1'b0;
      O_SA_START <= 1'b0;
      if (accept) begin
`ifdef SA_SCHED_TIMEOUT_EN
        err_q <= 1'b0;
`endif
        if (I_NUM_BLK == '0) begin
          state  <= ST_DONE;
          O_DONE <= 1'b1;
        end else begin
          state     <= ST_LD_W;
          num_blk   <= I_NUM_BLK;
          blk       <= '0;
          w_loaded  <= 1'b0;
          O_BUSY    <= 1'b1;
          O_W_RD_EN <= 1'b1;
        end
      end else begin
        case (state)
          ST_LD_W: begin
            state       <= ST_LD_X;
            O_X_RD_EN   <= 1'b1;
            O_X_RD_ADDR <= blk;
          end
          ST_LD_X: begin
            // Weight data answers the LD_W strobe; later blocks reuse the tile.
            if (!w_loaded) begin
              w_q      <= I_W_RD_DATA;
              w_loaded <= 1'b1;
            end
            state <= ST_CAP;
          end
          ST_CAP: begin
            x_q        <= I_X_RD_DATA;
            O_SA_START <= 1'b1;
            state      <= ST_FIRE;
          end
          ST_FIRE: begin
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (I_SA_OUT_VLD) begin
              O_RES     <= I_SA_OUT;
              O_RES_IDX <= blk;
              O_RES_VLD <= 1'b1;
              state     <= ST_PUSH;
            end
`ifdef SA_SCHED_TIMEOUT_EN
            else if (wd_expired) begin
              err_q  <= 1'b1;
              O_BUSY <= 1'b0;
              state  <= ST_ERR;
            end
`endif
          end
          ST_PUSH: begin
            if (I_RES_RDY) begin
              O_RES_VLD <= 1'b0;
              if (last_blk) begin
                O_BUSY <= 1'b0;
                O_DONE <= 1'b1;
                state  <= ST_DONE;
              end else begin
                blk         <= blk + 1'b1;
                O_X_RD_EN   <= 1'b1;
                O_X_RD_ADDR <= blk + 1'b1;
                state       <= ST_LD_X;
              end
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            // IDLE and ERR hold here until accept.
            state <= state;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sa_tile_scheduler.sv
// Randomized bench for sa_tile_scheduler: buffer and SA models, an event
// timeline predicted from block count, SA latency and ready stalls, and a result scoreboard.
`timescale 1ns/1ps
module tb_sa_tile_scheduler;
  import sa_pkg::*;

  localparam int S       = 2;
  localparam int X_R     = 2;
  localparam int BLK_W   = 8;
  localparam int TIMEOUT = 16;
  localparam int XW      = S * X_R * 8;
  localparam int WW      = S * 64 * 8;
  localparam int RW      = X_R * 64 * 8;

  // ---------------- clock / reset / DUT ----------------
  logic             clk;
  logic             I_RST, I_START;
  logic [BLK_W-1:0] I_NUM_BLK;
  logic             O_BUSY, O_DONE, O_ERR, O_W_RD_EN, O_X_RD_EN, O_SA_START, O_RES_VLD;
  logic [WW-1:0]    I_W_RD_DATA, O_SA_W;
  logic [XW-1:0]    I_X_RD_DATA, O_SA_X;
  logic [BLK_W-1:0] O_X_RD_ADDR, O_RES_IDX;
  logic             I_SA_OUT_VLD, I_RES_RDY;
  logic [RW-1:0]    I_SA_OUT, O_RES;
  sa_state_t        dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sa_tile_scheduler #(.S(S), .X_R(X_R), .BLK_W(BLK_W), .TIMEOUT(TIMEOUT)) dut (
    .I_CLK(clk), .I_RST(I_RST), .I_START(I_START), .I_NUM_BLK(I_NUM_BLK),
    .O_BUSY(O_BUSY), .O_DONE(O_DONE), .O_ERR(O_ERR),
    .O_W_RD_EN(O_W_RD_EN), .I_W_RD_DATA(I_W_RD_DATA),
    .O_X_RD_EN(O_X_RD_EN), .O_X_RD_ADDR(O_X_RD_ADDR), .I_X_RD_DATA(I_X_RD_DATA),
    .O_SA_START(O_SA_START), .O_SA_X(O_SA_X), .O_SA_W(O_SA_W),
    .I_SA_OUT_VLD(I_SA_OUT_VLD), .I_SA_OUT(I_SA_OUT),
    .O_RES_VLD(O_RES_VLD), .O_RES(O_RES), .O_RES_IDX(O_RES_IDX), .I_RES_RDY(I_RES_RDY),
    .O_DBG_STATE(dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [1023:0] got, input logic [1023:0] want);
    n_checks++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got(lo192)=%h want(lo192)=%h", tag, got[191:0], want[191:0]);
    end
  endtask

  task automatic cmp_q(input string tag, input int got[$], input int want[$]);
    check({tag, "_count"}, got.size(), want.size());
    for (int i = 0; i < got.size() && i < want.size(); i++)
      check({tag, "_val"}, got[i], want[i]);
  endtask

  function automatic logic [1023:0] rand_wide();
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference product: X (X_R x S) times W (S x 64), 8-bit wrap-around elements.
  function automatic logic [RW-1:0] sa_ref(input logic [XW-1:0] x, input logic [WW-1:0] w);
    logic [RW-1:0] r;
    logic [7:0]    acc;
    r = '0;
    for (int i = 0; i < X_R; i++)
      for (int c = 0; c < 64; c++) begin
        acc = 8'd0;
        for (int k = 0; k < S; k++)
          acc = acc + 8'(x[(i*S+k)*8 +: 8] * w[(k*64+c)*8 +: 8]);
        r[(i*64+c)*8 +: 8] = acc;
      end
    return r;
  endfunction

  // ---------------- buffer + SA environment ----------------
  logic [WW-1:0] w_mem;
  logic [XW-1:0] x_mem [0:15];
  logic [WW-1:0] sa_w_cap;
  logic [XW-1:0] sa_x_cap;
  int            sa_lat = 0;
  int            sa_cd  = 0;
  logic          spur_vld = 1'b0;
  int            cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    logic             w_seen, x_seen, s_seen, mvld;
    logic [BLK_W-1:0] a;
    w_seen = O_W_RD_EN;
    x_seen = O_X_RD_EN;
    s_seen = O_SA_START;
    a      = O_X_RD_ADDR;
    if (s_seen) begin
      sa_x_cap = O_SA_X;
      sa_w_cap = O_SA_W;
      sa_cd    = sa_lat;
    end
    #1;
    I_W_RD_DATA = w_seen ? w_mem : rand_wide();
    I_X_RD_DATA = x_seen ? x_mem[a[3:0]] : XW'($urandom);
    if (sa_cd > 0) begin
      sa_cd--;
      mvld = (sa_cd == 0);
    end else begin
      mvld = 1'b0;
    end
    I_SA_OUT_VLD = mvld | spur_vld;
    I_SA_OUT     = mvld ? sa_ref(sa_x_cap, sa_w_cap) : rand_wide();
  end

  // ---------------- ready driver + monitor / scoreboard ----------------
  int            t0 = 0;
  int            stall [0:15];
  int            push_cyc = 0;
  int            hs_cnt = 0;
  int            sa_cnt = 0;
  int            busy_cyc = 0;
  int            vld_cyc = 0;
  bit            mon_on = 1'b0;
  int            ev_w[$], ev_x[$], ev_xa[$], ev_s[$], ev_hs[$], ev_done[$];
  logic [RW-1:0] exp_q[$];
  int            exp_idx_q[$];

  always @(negedge clk) begin
    int rel;
    rel = cyc - t0;
    if (O_RES_VLD) begin
      I_RES_RDY = (push_cyc >= ((hs_cnt < 16) ? stall[hs_cnt] : 0));
      push_cyc++;
    end else begin
      I_RES_RDY = 1'($urandom_range(0, 1));
      push_cyc  = 0;
    end
    if (mon_on) begin
      if (O_W_RD_EN) ev_w.push_back(rel);
      if (O_X_RD_EN) begin
        ev_x.push_back(rel);
        ev_xa.push_back(int'(O_X_RD_ADDR));
      end
      if (O_SA_START) begin
        ev_s.push_back(rel);
        check("sa_x_operand", O_SA_X, x_mem[sa_cnt % 16]);
        check("sa_w_operand", O_SA_W, w_mem);
        sa_cnt++;
      end
      if (O_BUSY) busy_cyc++;
      if (O_DONE) ev_done.push_back(rel);
      if (O_RES_VLD) begin
        vld_cyc++;
        if (exp_q.size() == 0) begin
          check("res_vld_unexpected", O_RES_VLD, 1'b0);
        end else begin
          check("res_data", O_RES, exp_q[0]);
          check("res_idx", O_RES_IDX, exp_idx_q[0]);
        end
        if (I_RES_RDY) begin
          ev_hs.push_back(rel);
          hs_cnt++;
          if (exp_q.size() > 0) begin
            void'(exp_q.pop_front());
            void'(exp_idx_q.pop_front());
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_logs();
    ev_w.delete(); ev_x.delete(); ev_xa.delete(); ev_s.delete(); ev_hs.delete(); ev_done.delete();
    busy_cyc = 0;
    vld_cyc  = 0;
    hs_cnt   = 0;
    sa_cnt   = 0;
  endtask

  task automatic prep_mem(input int n);
    w_mem = rand_wide();
    for (int b = 0; b < 16; b++) x_mem[b] = (b < n) ? XW'($urandom) : '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ctrl"}, {O_BUSY, O_DONE, O_ERR, O_W_RD_EN, O_X_RD_EN, O_SA_START, O_RES_VLD}, 7'd0);
    check({tag, "_idx"}, {O_X_RD_ADDR, O_RES_IDX}, 16'd0);
    check({tag, "_sa_x"}, O_SA_X, 0);
    check({tag, "_sa_w"}, O_SA_W, 0);
    check({tag, "_res"}, O_RES, 0);
  endtask

  // Runs one job; timeline predicted from block count, SA latency and stalls.
  task automatic run_job(input int n, input int lat, input bit poke);
    int m_w[$], m_x[$], m_xa[$], m_s[$], m_hs[$];
    int ldx, fire, hs, exp_done, budget;
    sa_lat = lat;
    prep_mem(n);
    exp_q.delete();
    exp_idx_q.delete();
    ldx = 2;
    hs  = 0;
    if (n > 0) m_w.push_back(1);
    for (int b = 0; b < n; b++) begin
      m_x.push_back(ldx);
      m_xa.push_back(b);
      fire = ldx + 2;
      m_s.push_back(fire);
      hs = fire + lat + 1 + stall[b];
      m_hs.push_back(hs);
      ldx = hs + 1;
      exp_q.push_back(sa_ref(x_mem[b], w_mem));
      exp_idx_q.push_back(b);
    end
    exp_done = (n == 0) ? 1 : hs + 1;

    @(negedge clk); #1;
    t0 = cyc;
    clear_logs();
    I_START   = 1'b1;
    I_NUM_BLK = BLK_W'(n);
    @(negedge clk); #1;
    I_START   = 1'b0;
    I_NUM_BLK = BLK_W'($urandom);
    check("err_low_at_1", O_ERR, 1'b0);
    check("busy_at_1", O_BUSY, n > 0);
    budget = exp_done + 60;
    while (ev_done.size() == 0 && (cyc - t0) < budget) begin
      @(negedge clk); #1;
      if (poke && (cyc - t0) == 10) begin
        I_START   = 1'b1;
        I_NUM_BLK = 8'd5;
      end else begin
        I_START = 1'b0;
      end
    end
    I_START = 1'b0;
    check("done_seen", ev_done.size(), 1);
    repeat (8) @(negedge clk);
    #1;
    check("done_pulses", ev_done.size(), 1);
    if (ev_done.size() > 0) check("done_cycle", ev_done[0], exp_done);
    cmp_q("w_rd", ev_w, m_w);
    cmp_q("x_rd", ev_x, m_x);
    cmp_q("x_addr", ev_xa, m_xa);
    cmp_q("sa_start", ev_s, m_s);
    cmp_q("res_hs", ev_hs, m_hs);
    check("busy_cycles", busy_cyc, hs);
    check("results_left", exp_q.size(), 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    I_RST        = 1'b1;
    I_START      = 1'b0;
    I_NUM_BLK    = '0;
    I_W_RD_DATA  = '0;
    I_X_RD_DATA  = '0;
    I_SA_OUT_VLD = 1'b0;
    I_SA_OUT     = '0;
    I_RES_RDY    = 1'b0;
    for (int i = 0; i < 16; i++) stall[i] = 0;
    prep_mem(0);
    repeat (3) @(negedge clk);
    check_zero("reset");
    I_RST  = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(negedge clk);

    // single block, SA latency 20
    run_job(1, 20, 1'b0);

    // three blocks with a 5-cycle downstream stall on block 1
    stall[1] = 5;
    run_job(3, $urandom_range(3, 12), 1'b0);
    stall[1] = 0;

    // zero-block job
    run_job(0, 5, 1'b0);

    // start pulse while busy is ignored
    run_job(2, 20, 1'b1);

    // randomized jobs
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < 16; i++) stall[i] = $urandom_range(0, 3);
      run_job($urandom_range(1, 6), $urandom_range(1, 15), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 16; i++) stall[i] = 0;

    // asynchronous reset in the middle of WAIT
    prep_mem(2);
    exp_q.delete();
    exp_idx_q.delete();
    sa_lat = 20;
    @(negedge clk); #1;
    t0 = cyc;
    clear_logs();
    I_START   = 1'b1;
    I_NUM_BLK = 8'd2;
    @(negedge clk); #1;
    I_START = 1'b0;
    while ((cyc - t0) < 10) begin
      @(negedge clk); #1;
    end
    check("pre_reset_busy", O_BUSY, 1'b1);
    #2;
    I_RST = 1'b1;
    #1;
    check_zero("async_reset");
    repeat (2) @(negedge clk);
    #1;
    I_RST = 1'b0;
    clear_logs();
    @(negedge clk); #1;
    spur_vld = 1'b1;
    @(posedge clk); #2;
    spur_vld = 1'b0;
    repeat (30) @(negedge clk);
    #1;
    check("post_reset_res_vld", vld_cyc, 0);
    check("post_reset_done", ev_done.size(), 0);
    check("post_reset_busy", busy_cyc, 0);

`ifdef SA_SCHED_TIMEOUT_EN
    // SA never answers: watchdog trips TIMEOUT+1 cycles after FIRE
    prep_mem(1);
    sa_lat = 0;
    @(negedge clk); #1;
    t0 = cyc;
    clear_logs();
    I_START   = 1'b1;
    I_NUM_BLK = 8'd1;
    @(negedge clk); #1;
    I_START = 1'b0;
    while ((cyc - t0) < 26) begin
      @(negedge clk); #1;
      if ((cyc - t0) == 4 + TIMEOUT) begin
        check("wd_err_before", O_ERR, 1'b0);
        check("wd_busy_before", O_BUSY, 1'b1);
      end
      if ((cyc - t0) == 5 + TIMEOUT) begin
        check("wd_err_set", O_ERR, 1'b1);
        check("wd_busy_clear", O_BUSY, 1'b0);
      end
    end
    check("wd_err_sticky", O_ERR, 1'b1);
    check("wd_no_done", ev_done.size(), 0);
    run_job(2, 6, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit got=running want=finished");
    $fatal(1, "time limit");
  end

endmodule
